row_scan_driver: RTL and testbench



---
 rtl/row_scan_driver.sv | 131 +++++++++++++
 tb/tb_row_scan_driver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/row_scan_driver.sv
// Row scanner for the LED matrix 3-to-8 decoder: blank, then dwell, per row, with row-load and frame-done strobes.
// Optional descending scan selected by the `dir` port when ROW_SCAN_REVERSE_EN is defined.
module row_scan_driver #(
    parameter int N_ROWS       = 8,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4,
    localparam int ROW_W       = $clog2(N_ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
`ifdef ROW_SCAN_REVERSE_EN
    input  logic             dir,
`endif
    output logic [ROW_W-1:0] row_sel,
    output logic             dec_ena,
    output logic             row_load,
    output logic             frame_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK_CYCLES - 1);
    localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [ROW_W-1:0] r_row;
    logic             r_dec_ena;
    logic             r_row_load;
    logic             r_frame_done;

    logic [1:0]       w_nxt_state;
    logic [TMR_W-1:0] w_nxt_timer;
    logic [ROW_W-1:0] w_nxt_row;
    logic [ROW_W-1:0] w_row_start;
    logic [ROW_W-1:0] w_row_step;
    logic [ROW_W-1:0] w_row_end;

`ifdef ROW_SCAN_REVERSE_EN
    logic r_dir;

    // Direction is captured once at frame start; later changes on dir are ignored until the next IDLE exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= 1'b0;
        end else if (r_state == S_IDLE && ena) begin
            r_dir <= dir;
        end
    end

    assign w_row_start = dir ? ROW_LAST : '0;
    assign w_row_step  = r_dir ? (r_row - 1'b1) : (r_row + 1'b1);
    assign w_row_end   = r_dir ? '0 : ROW_LAST;
`else
    assign w_row_start = '0;
    assign w_row_step  = r_row + 1'b1;
    assign w_row_end   = ROW_LAST;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_row   = r_row;
        if (!ena) begin
            w_nxt_state = S_IDLE;
            w_nxt_timer = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nxt_state = S_BLANK;
                    w_nxt_timer = BLANK_LD;
                    w_nxt_row   = w_row_start;
                end
                S_BLANK: begin
                    if (r_timer == '0) begin
                        w_nxt_state = S_DRIVE;
                        w_nxt_timer = DWELL_LD;
                    end else begin
                        w_nxt_timer = r_timer - 1'b1;
                    end
                end
                S_DRIVE: begin
                    // Row select only moves on the edge into BLANK, so it is stable while the decoder drives.
                    if (r_timer == '0) begin
                        w_nxt_state = S_BLANK;
                        w_nxt_timer = BLANK_LD;
                        w_nxt_row   = w_row_step;
                    end else begin
                        w_nxt_timer = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_timer = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state view so each strobe lines up with the cycle it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_row        <= '0;
            r_dec_ena    <= 1'b0;
            r_row_load   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_timer      <= w_nxt_timer;
            r_row        <= w_nxt_row;
            r_dec_ena    <= (w_nxt_state == S_DRIVE);
            r_row_load   <= (w_nxt_state == S_BLANK) && (r_state != S_BLANK);
            r_frame_done <= (w_nxt_state == S_DRIVE) && (w_nxt_timer == '0) && (w_nxt_row == w_row_end);
        end
    end

    assign row_sel    = r_row;
    assign dec_ena    = r_dec_ena;
    assign row_load   = r_row_load;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_row_scan_driver.sv
// Directed bench for row_scan_driver with N_ROWS=8, DWELL_CYCLES=3, BLANK_CYCLES=2.
// Reverse-scan vectors are included when ROW_SCAN_REVERSE_EN is defined.
module tb_row_scan_driver;

    localparam int NR    = 8;
    localparam int DW    = 3;
    localparam int BL    = 2;
    localparam int PER   = BL + DW;
    localparam int FRAME = NR * PER;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
`ifdef ROW_SCAN_REVERSE_EN
    logic       dir = 1'b0;
`endif
    logic [2:0] row_sel;
    logic       dec_ena;
    logic       row_load;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_loads;

    always #5 clk = ~clk;

    row_scan_driver #(
        .N_ROWS      (NR),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
`ifdef ROW_SCAN_REVERSE_EN
        .dir       (dir),
`endif
        .row_sel   (row_sel),
        .dec_ena   (dec_ena),
        .row_load  (row_load),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for cycle c (1-based) of a running scan.
    task automatic chk_cyc(input int c, input bit rev);
        int row;
        int ph;
        row = ((c - 1) / PER) % NR;
        if (rev) row = NR - 1 - row;
        ph = (c - 1) % PER;
        chk($sformatf("c%0d row_sel", c), 32'(row_sel), 32'(row));
        chk($sformatf("c%0d dec_ena", c), 32'(dec_ena), (ph >= BL) ? 32'd1 : 32'd0);
        chk($sformatf("c%0d row_load", c), 32'(row_load), (ph == 0) ? 32'd1 : 32'd0);
        chk($sformatf("c%0d frame_done", c), 32'(frame_done), (c % FRAME == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_idle(input string tag, input int exp_row);
        chk({tag, " row_sel"}, 32'(row_sel), 32'(exp_row));
        chk({tag, " dec_ena"}, 32'(dec_ena), 32'd0);
        chk({tag, " row_load"}, 32'(row_load), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk_idle("reset", 0);
        rst = 1'b0;
        step();
        step();
        chk_idle("idle_ena_low", 0);

        // Two full frames from row 0.
        ena = 1'b1;
        n_loads = 0;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            step();
            chk_cyc(c, 1'b0);
            if (c <= FRAME && row_load) n_loads++;
        end
        chk("loads_per_frame", 32'(n_loads), 32'(NR));

        // Stop right after the last dwell: select holds row 7.
        ena = 1'b0;
        step();
        chk_idle("stop_hold", NR - 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle($sformatf("stop_idle%0d", i), NR - 1);
        end

        // Abort mid-dwell of row 0.
        ena = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk_cyc(c, 1'b0);
        end
        ena = 1'b0;
        step();
        chk_idle("abort", 0);
        step();
        chk_idle("abort_idle", 0);

        // Restart, then reset during the dwell of row 5.
        ena = 1'b1;
        for (int c = 1; c <= 5 * PER + BL + 1; c++) begin
            step();
            chk_cyc(c, 1'b0);
        end
        rst = 1'b1;
        step();
        chk_idle("rst_mid_dwell", 0);
        rst = 1'b0;
        for (int c = 1; c <= PER + 1; c++) begin
            step();
            chk_cyc(c, 1'b0);
        end

`ifdef ROW_SCAN_REVERSE_EN
        ena = 1'b0;
        step();
        step();
        dir = 1'b1;
        ena = 1'b1;
        for (int c = 1; c <= FRAME + PER; c++) begin
            step();
            chk_cyc(c, 1'b1);
            if (c == 12) dir = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
